// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks every register-file address, captures the
// combinational read data and streams each register out on valid/ready.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_index_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, RD, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   out_index_q, out_index_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    // abort only matters once a dump is running; start always wins in IDLE
    if (abort_i && state_q != IDLE) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      rd_addr_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) begin
          rd_addr_d = '0;
          state_d   = RD;
        end
        RD: begin
          out_data_d  = rd_data_i;
          out_index_d = rd_addr_q;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
        SEND: if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (out_index_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = RD;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign rd_addr_o   = rd_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_index_o = out_index_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected beats are queued when a
// dump is started and popped as the consumer accepts them.
module tb_regfile_dump_reader;

  localparam int N = 32;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] dat;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [4:0]  rd_addr, out_index;
  logic [31:0] rd_data, out_data;
  logic        out_valid, busy, done;

  logic [31:0] rf [N];
  beat_t       q[$];
  int          n_cmp = 0, n_err = 0, done_cnt = 0;
  logic        hold_v = 1'b0;
  beat_t       hold_b;

  always #5 clk = ~clk;

  // register file model: x0 hard-wired to zero, combinational read
  assign rd_data = (rd_addr == 5'd0) ? 32'h0 : rf[rd_addr];

  regfile_dump_reader dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .rd_addr_o(rd_addr), .rd_data_i(rd_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_index_o(out_index),
    .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rf_write(input int a, input logic [31:0] d);
    if (a != 0) rf[a] = d;
  endtask

  task automatic push_all();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.idx = 5'(i);
      b.dat = (i == 0) ? 32'h0 : rf[i];
      q.push_back(b);
    end
  endtask

  // inputs only move just after posedge, so negedge sees what the next edge samples
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (hold_v && out_valid) begin
        chk("hold_idx", {27'h0, out_index}, {27'h0, hold_b.idx});
        chk("hold_dat", out_data, hold_b.dat);
      end
      hold_v = out_valid && !out_ready && !abort;
      hold_b = '{idx: out_index, dat: out_data};
      if (out_valid && out_ready && !abort) begin
        chk("q_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          beat_t e;
          e = q.pop_front();
          chk("beat_idx", {27'h0, out_index}, {27'h0, e.idx});
          chk("beat_dat", out_data, e.dat);
        end
      end
    end
  end

  // pushes expectations, pulses start, runs until done; inj>=0 re-pulses start at that beat
  task automatic do_dump(input bit rnd, input int inj, output int cyc);
    bit injected = 1'b0;
    push_all();
    start = 1'b1;
    cyc = 0;
    while (cyc < 600) begin
      tick();
      cyc++;
      start = 1'b0;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (inj >= 0 && !injected && out_valid && out_index == 5'(inj)) begin
        start = 1'b1;
        injected = 1'b1;
      end
      if (done) break;
    end
    chk("done_seen", {31'h0, done}, 32'd1);
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("q_drained", q.size(), 32'd0);
  endtask

  initial begin
    int cyc, dc, guard;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) rf[i] = 32'(i) * 32'h1111_1111;
    tick(); tick();
    chk("rst_addr", {27'h0, rd_addr}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_index", {27'h0, out_index}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    reset = 1'b0;
    abort = 1'b1;
    tick();
    chk("abort_idle_busy", {31'h0, busy}, 32'h0);
    abort = 1'b0;

    // 1: zero-wait consumer, latency check
    dc = done_cnt;
    do_dump(1'b0, -1, cyc);
    chk("done_latency", cyc, 32'd65);
    chk("done_once_t1", done_cnt - dc, 32'd1);

    // 2: random backpressure
    dc = done_cnt;
    do_dump(1'b1, -1, cyc);
    chk("done_once_t2", done_cnt - dc, 32'd1);

    // 3: abort during SEND of beat 10; start and abort together also tested
    dc = done_cnt;
    push_all();
    start = 1'b1;
    abort = 1'b1;
    guard = 0;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_beats_abort", {31'h0, busy}, 32'h1);
    while (!(out_valid && out_index == 5'd10) && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_beat10", {31'h0, out_valid}, 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_addr", {27'h0, rd_addr}, 32'h0);
    chk("abort_left", q.size(), 32'd22);
    q.delete();
    repeat (70) tick();
    chk("abort_no_done", done_cnt - dc, 32'd0);
    do_dump(1'b0, -1, cyc);

    // 4: start re-pulsed during beat 5 is ignored
    dc = done_cnt;
    do_dump(1'b1, 5, cyc);
    chk("done_once_t4", done_cnt - dc, 32'd1);

    // 5: reset during RD of index 20
    push_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(busy && !out_valid && rd_addr == 5'd20) && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_rd20", {27'h0, rd_addr}, 32'd20);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("mid_rst_addr", {27'h0, rd_addr}, 32'h0);
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_index", {27'h0, out_index}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    q.delete();
    repeat (5) tick();
    chk("stay_idle", {31'h0, busy}, 32'h0);

    // 6: write to x0 has no effect, last register reported last
    rf_write(0, 32'hFFFF_FFFF);
    rf_write(31, 32'hDEAD_BEEF);
    dc = done_cnt;
    do_dump(1'b0, -1, cyc);
    chk("done_once_t6", done_cnt - dc, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
